// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I-subset core, plus ALU/immediate decoders and instret.
// Outputs are combinational from state and instruction fields; memory waits hold FETCH/MEMREAD/MEMWRITE.
module riscv_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [6:0]       op_i,
  input  logic [2:0]       funct3_i,
  input  logic             funct7b5_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pcwrite_o,
  output logic             adrsrc_o,
  output logic             memwrite_o,
  output logic             irwrite_o,
  output logic [1:0]       resultsrc_o,
  output logic [1:0]       alusrca_o,
  output logic [1:0]       alusrcb_o,
  output logic [2:0]       alucontrol_o,
  output logic [1:0]       immsrc_o,
  output logic             regwrite_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instret_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             pcupdate, branch, memwrite_s, irwrite_s, regwrite_s, illegal_s, retire;
  logic [1:0]       aluop;

  always_comb begin
    state_d     = S_FETCH;
    pcupdate    = 1'b0;
    branch      = 1'b0;
    adrsrc_o    = 1'b0;
    memwrite_s  = 1'b0;
    irwrite_s   = 1'b0;
    regwrite_s  = 1'b0;
    illegal_s   = 1'b0;
    retire      = 1'b0;
    resultsrc_o = 2'b00;
    alusrca_o   = 2'b00;
    alusrcb_o   = 2'b00;
    aluop       = 2'b00;
    case (state_q)
      S_FETCH: begin
        alusrcb_o   = 2'b10;
        resultsrc_o = 2'b10;
        if (mem_ready_i) begin
          irwrite_s = 1'b1;
          pcupdate  = 1'b1;
          state_d   = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        alusrca_o = 2'b01;
        alusrcb_o = 2'b01;
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      illegal_s = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca_o = 2'b10;
        alusrcb_o = 2'b01;
        state_d   = (op_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrsrc_o = 1'b1;
        state_d  = mem_ready_i ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        resultsrc_o = 2'b01;
        regwrite_s  = 1'b1;
        retire      = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc_o   = 1'b1;
        memwrite_s = 1'b1;
        retire     = mem_ready_i;
        state_d    = mem_ready_i ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alusrca_o = 2'b10;
        aluop     = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alusrca_o = 2'b10;
        alusrcb_o = 2'b01;
        aluop     = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_s = 1'b1;
        retire     = 1'b1;
      end
      S_JAL: begin
        alusrca_o = 2'b01;
        alusrcb_o = 2'b10;
        pcupdate  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alusrca_o = 2'b10;
        aluop     = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    alucontrol_o = 3'b000;
    case (aluop)
      2'b00: alucontrol_o = 3'b000;
      2'b01: alucontrol_o = 3'b001;
      default: begin
        case (funct3_i)
          3'b000:  alucontrol_o = (op_i[5] & funct7b5_i) ? 3'b001 : 3'b000;
          3'b010:  alucontrol_o = 3'b101;
          3'b110:  alucontrol_o = 3'b011;
          3'b111:  alucontrol_o = 3'b010;
          default: alucontrol_o = 3'b000;
        endcase
      end
    endcase
  end

  // Immediate format depends only on the opcode so the extender is valid during DECODE.
  always_comb begin
    immsrc_o = 2'b00;
    case (op_i)
      OP_SW:   immsrc_o = 2'b01;
      OP_BEQ:  immsrc_o = 2'b10;
      OP_JAL:  immsrc_o = 2'b11;
      default: immsrc_o = 2'b00;
    endcase
  end

  assign pcwrite_o  = ~reset_i & (pcupdate | (branch & zero_i));
  assign memwrite_o = ~reset_i & memwrite_s;
  assign irwrite_o  = ~reset_i & irwrite_s;
  assign regwrite_o = ~reset_i & regwrite_s;
  assign illegal_o  = ~reset_i & illegal_s;
  assign instret_o  = instret_q;
  assign instret_d  = retire ? instret_q + CNT_W'(1) : instret_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench for riscv_multicycle_ctrl: per-cycle expected control vectors are queued, then replayed.
// CNT_W is kept small so the instret wrap is reached.
module tb_riscv_multicycle_ctrl;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          reset, zero, mem_ready, funct7b5;
  logic [6:0]    op;
  logic [2:0]    funct3;
  logic          pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic [1:0]    resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0]    alucontrol;
  logic [TW-1:0] instret;

  riscv_multicycle_ctrl #(.CNT_W(TW)) dut (
    .clk_i(clk), .reset_i(reset), .op_i(op), .funct3_i(funct3), .funct7b5_i(funct7b5),
    .zero_i(zero), .mem_ready_i(mem_ready), .pcwrite_o(pcwrite), .adrsrc_o(adrsrc),
    .memwrite_o(memwrite), .irwrite_o(irwrite), .resultsrc_o(resultsrc), .alusrca_o(alusrca),
    .alusrcb_o(alusrcb), .alucontrol_o(alucontrol), .immsrc_o(immsrc), .regwrite_o(regwrite),
    .illegal_o(illegal), .instret_o(instret)
  );

  always #5 clk = ~clk;

  // {pcw, adr, memw, irw, res[2], srca[2], srcb[2], aluc[3], imm[2], regw, ill}
  typedef logic [16:0] vec_t;
  typedef struct {
    vec_t e;
    logic rst;
    logic rdy;
    int   step;
  } ent_t;

  ent_t          sb[$];
  int            tests = 0, failed = 0, step_n = 0;
  logic [TW-1:0] exp_instret = '0;

  function automatic vec_t mk(logic pcw, logic adr, logic memw, logic irw, logic [1:0] res,
                              logic [1:0] sra, logic [1:0] srb, logic [2:0] aluc,
                              logic [1:0] imm, logic regw, logic ill);
    return {pcw, adr, memw, irw, res, sra, srb, aluc, imm, regw, ill};
  endfunction

  function automatic void push(logic rst, logic rdy, vec_t e);
    ent_t en;
    en.e = e; en.rst = rst; en.rdy = rdy; en.step = step_n;
    step_n++;
    sb.push_back(en);
  endfunction

  // Apply one queued cycle, sample at the falling edge, leave #1 after the next rising edge.
  task automatic step_dut(output ent_t en, output vec_t got);
    en = sb.pop_front();
    reset = en.rst;
    mem_ready = en.rdy;
    @(negedge clk);
    got = {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb, alucontrol,
           immsrc, regwrite, illegal};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ent_t en; vec_t got;
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0;
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    @(posedge clk); #1;
    push(1, 1, mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
    push(1, 1, mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
    while (sb.size() != 0) begin
      step_dut(en, got); tests++;
      if (got !== en.e) begin failed++; $display("FAIL reset step %0d: got %b want %b", en.step, got, en.e); end
    end
    tests++;
    if (instret !== '0) begin failed++; $display("FAIL reset_instret: got %0d want 0", instret); end
  endtask

  task automatic test_lw(input int waits);
    ent_t en; vec_t got;
    op = 7'b0000011; funct3 = 3'b010;
    push(0, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
    push(0, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0));
    push(0, 1, mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0));
    for (int i = 0; i < waits; i++) push(0, 0, mk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0));
    push(0, 1, mk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0));
    push(0, 1, mk(0,0,0,0,2'b01,2'b00,2'b00,3'b000,2'b00,1,0));
    exp_instret++;
    while (sb.size() != 0) begin
      step_dut(en, got); tests++;
      if (got !== en.e) begin failed++; $display("FAIL lw step %0d: got %b want %b", en.step, got, en.e); end
    end
    tests++;
    if (instret !== exp_instret) begin failed++; $display("FAIL lw_instret: got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_sw_wait();
    ent_t en; vec_t got;
    op = 7'b0100011; funct3 = 3'b010;
    push(0, 0, mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0,0));
    push(0, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b01,0,0));
    push(0, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b01,0,0));
    push(0, 1, mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0));
    for (int i = 0; i < 3; i++) push(0, 0, mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0));
    push(0, 1, mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0));
    exp_instret++;
    while (sb.size() != 0) begin
      step_dut(en, got); tests++;
      if (got !== en.e) begin failed++; $display("FAIL sw step %0d: got %b want %b", en.step, got, en.e); end
    end
    tests++;
    if (instret !== exp_instret) begin failed++; $display("FAIL sw_instret: got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic [1:0] srcb, input logic [2:0] aluc);
    ent_t en; vec_t got;
    op = o; funct3 = f3; funct7b5 = f7;
    push(0, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
    push(0, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0));
    push(0, 1, mk(0,0,0,0,2'b00,2'b10,srcb,aluc,2'b00,0,0));
    push(0, 1, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,0));
    exp_instret++;
    while (sb.size() != 0) begin
      step_dut(en, got); tests++;
      if (got !== en.e) begin failed++; $display("FAIL alu op=%b f3=%b step %0d: got %b want %b", o, f3, en.step, got, en.e); end
    end
    tests++;
    if (instret !== exp_instret) begin failed++; $display("FAIL alu_instret: got %0d want %0d", instret, exp_instret); end
    funct7b5 = 1'b0;
  endtask

  task automatic test_beq(input logic z);
    ent_t en; vec_t got;
    op = 7'b1100011; funct3 = 3'b000; zero = z;
    push(0, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b10,0,0));
    push(0, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0,0));
    push(0, 1, mk(z,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0,0));
    exp_instret++;
    while (sb.size() != 0) begin
      step_dut(en, got); tests++;
      if (got !== en.e) begin failed++; $display("FAIL beq zero=%b step %0d: got %b want %b", z, en.step, got, en.e); end
    end
    tests++;
    if (instret !== exp_instret) begin failed++; $display("FAIL beq_instret: got %0d want %0d", instret, exp_instret); end
    zero = 1'b0;
  endtask

  task automatic test_jal();
    ent_t en; vec_t got;
    op = 7'b1101111;
    push(0, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b11,0,0));
    push(0, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b11,0,0));
    push(0, 1, mk(1,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b11,0,0));
    push(0, 1, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b11,1,0));
    exp_instret++;
    while (sb.size() != 0) begin
      step_dut(en, got); tests++;
      if (got !== en.e) begin failed++; $display("FAIL jal step %0d: got %b want %b", en.step, got, en.e); end
    end
    tests++;
    if (instret !== exp_instret) begin failed++; $display("FAIL jal_instret: got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_illegal();
    ent_t en; vec_t got;
    op = 7'b1111111;
    push(0, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
    push(0, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,1));
    push(0, 0, mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
    while (sb.size() != 0) begin
      step_dut(en, got); tests++;
      if (got !== en.e) begin failed++; $display("FAIL illegal step %0d: got %b want %b", en.step, got, en.e); end
    end
    tests++;
    if (instret !== exp_instret) begin failed++; $display("FAIL illegal_instret: got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_reset_mid();
    ent_t en; vec_t got;
    op = 7'b0100011; funct3 = 3'b010;
    push(0, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b01,0,0));
    push(0, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b01,0,0));
    push(0, 1, mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0));
    push(1, 0, mk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0));
    while (sb.size() != 0) begin
      step_dut(en, got); tests++;
      if (got !== en.e) begin failed++; $display("FAIL reset_mid step %0d: got %b want %b", en.step, got, en.e); end
    end
    exp_instret = '0;
    tests++;
    if (instret !== exp_instret) begin failed++; $display("FAIL reset_mid_instret: got %0d want 0", instret); end
    push(0, 0, mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0,0));
    while (sb.size() != 0) begin
      step_dut(en, got); tests++;
      if (got !== en.e) begin failed++; $display("FAIL reset_mid_fetch step %0d: got %b want %b", en.step, got, en.e); end
    end
  endtask

  initial begin
    test_reset();
    test_lw(0);
    test_lw(2);
    test_sw_wait();
    test_alu(7'b0110011, 3'b000, 1'b1, 2'b00, 3'b001);  // sub
    test_alu(7'b0010011, 3'b000, 1'b1, 2'b01, 3'b000);  // addi ignores funct7b5
    test_alu(7'b0110011, 3'b010, 1'b0, 2'b00, 3'b101);  // slt
    test_alu(7'b0110011, 3'b110, 1'b0, 2'b00, 3'b011);  // or
    test_alu(7'b0110011, 3'b111, 1'b0, 2'b00, 3'b010);  // and, instret wraps here
    test_beq(1'b1);
    test_beq(1'b0);
    test_jal();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
Main control FSM for the multicycle RV32I-subset core: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal. It sequences the shared-memory datapath, which holds the PC, OldPC, IR, Data, A/B and ALUOut registers. One instruction takes 3–5 states, plus wait cycles while unified memory is not ready. It also drives the ALU decoder, the immediate-select decoder and a retired-instruction counter.

Parameters:
CNT_W, 32, width of instret counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
op  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7b5  in  1  IR[30]
zero  in  1  ALU zero flag, same cycle
mem_ready  in  1  unified memory completes access this cycle
pcwrite  out  1  PC register enable
adrsrc  out  1  memory address: 0=PC, 1=ALUOut
memwrite  out  1  memory write strobe
irwrite  out  1  IR/OldPC enable
resultsrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
alusrca  out  2  00=PC, 01=OldPC, 10=RD1
alusrcb  out  2  00=RD2, 01=ImmExt, 10=constant 4
alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
immsrc  out  2  00 I, 01 S, 10 B, 11 J (decoded from op only)
regwrite  out  1  register file write enable
illegal  out  1  one-cycle pulse, unsupported opcode seen in DECODE
instret  out  CNT_W  retired-instruction count

Behaviour:
- State register 4 bits; all outputs are combinational from state/op/funct/zero/mem_ready. pcwrite = pcupdate | (branch & zero).
- While reset=1: next state FETCH; instret <= 0; pcwrite, irwrite, memwrite, regwrite and illegal forced 0. Reset mid-instruction abandons it with no write.
- Unlisted signals are 0 in each state. aluop 00=add, 01=sub, 10=funct decode.
- FETCH: adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10. If mem_ready: irwrite=1, pcupdate=1, next DECODE. Else hold in FETCH with irwrite=0, pcupdate=0.
- DECODE: alusrca=01, alusrcb=01, aluop=00 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other op -> FETCH, with illegal=1 for this cycle and instret not incremented.
- MEMADR: alusrca=10, alusrcb=01, aluop=00. Next MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: adrsrc=1, resultsrc=00. Next MEMWB when mem_ready, else hold.
- MEMWB: resultsrc=01, regwrite=1. Next FETCH.
- MEMWRITE: adrsrc=1, resultsrc=00, memwrite=1 for every cycle in the state. Next FETCH when mem_ready, else hold.
- EXECR: alusrca=10, alusrcb=00, aluop=10. Next ALUWB.
- EXECI: alusrca=10, alusrcb=01, aluop=10. Next ALUWB.
- ALUWB: resultsrc=00, regwrite=1. Next FETCH.
- JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1 (PC<=target, ALUOut<=OldPC+4). Next ALUWB.
- BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1. Next FETCH.
- ALU decode when aluop=10, by funct3:
  - 000: sub if op[5]&funct7b5, else add
  - 010: slt
  - 110: or
  - 111: and
  - others: add
- instret increments by 1 on the edge leaving MEMWB, ALUWB, BEQ, or MEMWRITE with mem_ready=1. Illegal opcodes and abandoned instructions do not count. Wraps at 2^CNT_W-1 -> 0.
- Unused state encodings: next state FETCH, all enables 0.

Test Plan:
- Reset for 3 cycles, mem_ready=1, release. First cycle: FETCH, irwrite=1, pcwrite=1, alusrcb=10, instret=0.
- lw (op=0000011), mem_ready=1. State sequence FETCH,DECODE,MEMADR,MEMREAD,MEMWB: regwrite=1 only in cycle 5 with resultsrc=01; instret=1. Repeat with mem_ready low for 2 cycles in MEMREAD: 7 cycles total, regwrite still pulses once.
- sw (op=0100011, funct3=010). memwrite=1 and adrsrc=1 only in the MEMWRITE state; immsrc=01. With mem_ready held low 3 cycles, memwrite stays high 4 cycles. No regwrite at any point.
- R-type sub (op=0110011, funct3=000, funct7b5=1): alucontrol=001 in EXECR. addi with funct7b5=1 (op=0010011): alucontrol=000. slt: 101; or: 011; and: 010.
- beq with zero=1: pcwrite=1 in the BEQ cycle. With zero=0: pcwrite=0. Both take 3 cycles, immsrc=10, instret +1. jal: pcwrite=1 in JAL, then regwrite=1 in ALUWB, immsrc=11.
- op=1111111: illegal=1 for one cycle in DECODE, next FETCH, instret unchanged. Assert reset during MEMWRITE: memwrite=0 that cycle, state FETCH after, instret=0.
